// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: show-ahead head register, sticky overflow.
// Define UART_RX_FIFO_LEVEL_EN to expose the fill level on port level.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              overflow
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              do_rd, do_wr, drop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        do_rd = rd & ~empty;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        do_wr = rx_done_tick & (~full | do_rd);
        drop  = rx_done_tick & full & ~rd;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        r_data_d   = r_data_q;

        if (reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            r_data_d   = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop)         overflow_d = 1'b1;
            else if (clr_ovf) overflow_d = 1'b0;
            // Bypass the incoming byte when it lands in the next head slot.
            if (do_wr && (wr_ptr_q == rd_ptr_d)) r_data_d = din;
            else                                 r_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        overflow_q <= overflow_d;
        r_data_q   <= r_data_d;
    end

    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem_q[wr_ptr_q] <= din;
    end

    assign r_data   = r_data_q;
    assign overflow = overflow_q;
`ifdef UART_RX_FIFO_LEVEL_EN
    assign level    = count_q;
`endif

endmodule
